// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and small helpers that turn a width code into byte counts and lane masks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Lane mask of an access of the given size sitting at lane 0.
    function automatic logic [3:0] size_mask(input logic [1:0] sizeCode);
        case (sizeCode)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Access size in bytes (1, 2 or 4).
    function automatic logic [2:0] size_bytes(input logic [1:0] sizeCode);
        case (sizeCode)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Loads accept B/H/W/BU/HU, stores accept only B/H/W.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 >= 3'b011;
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the data-memory port of the LSU.
// The slave side is the LSU itself; the master side is the core + memory.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wen;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_mask;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_wen, mem_address, mem_wdata, mem_byte_mask
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_wen, mem_address, mem_wdata, mem_byte_mask
    );
endinterface

// File: rtl/lsu_align.sv
// Purely combinational lane steering: splits an access into a first and
// second word, shifts store data into byte lanes, and reassembles and
// extends load data from the two captured memory words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rd0_i,
    input  logic [31:0] rd1_i,
    output logic        split_o,
    output logic [3:0]  mask0_o,
    output logic [3:0]  mask1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] rdata_o
);

    logic [3:0]  sizeMask;
    logic [4:0]  lowShift;
    logic [5:0]  highShift;
    logic [31:0] rawData;

    // Lane masks, shifted write data and extended read data for both halves.
    always_comb begin
        sizeMask  = size_mask(funct3_i[1:0]);
        lowShift  = {offset_i, 3'b000};
        highShift = 6'd32 - {1'b0, offset_i, 3'b000};

        split_o  = ({1'b0, offset_i} + size_bytes(funct3_i[1:0])) > 3'd4;
        mask0_o  = sizeMask << offset_i;
        mask1_o  = sizeMask >> (3'd4 - {1'b0, offset_i});
        wdata0_o = wdata_i << lowShift;
        wdata1_o = wdata_i >> highShift;

        rawData = (rd0_i >> lowShift) | (rd1_i << highShift);
        case (funct3_i)
            F3_B:    rdata_o = {{24{rawData[7]}}, rawData[7:0]};
            F3_H:    rdata_o = {{16{rawData[15]}}, rawData[15:0]};
            F3_BU:   rdata_o = {24'b0, rawData[7:0]};
            F3_HU:   rdata_o = {16'b0, rawData[15:0]};
            default: rdata_o = rawData;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time, performs one or two
// word accesses to an asynchronous-read data memory (two when the access
// straddles a word boundary) and returns a single-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORDS = 128
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    localparam logic [32:0] BYTE_LIMIT = 33'(WORDS) * 33'd4;

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rd0_q;
    logic [31:0] rd1_q;

    logic        accept;
    logic        reqErr;
    logic [32:0] lastByte;
    logic        split;
    logic [3:0]  mask0, mask1;
    logic [31:0] wdata0, wdata1;
    logic [31:0] alignedRdata;
    logic [31:0] wordAddr;

    lsu_align u_align (
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rd0_i    (rd0_q),
        .rd1_i    (rd1_q),
        .split_o  (split),
        .mask0_o  (mask0),
        .mask1_o  (mask1),
        .wdata0_o (wdata0),
        .wdata1_o (wdata1),
        .rdata_o  (alignedRdata)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign accept        = bus.req_valid && (state_q == IDLE);
    assign wordAddr      = {addr_q[31:2], 2'b00};

    // Decide at acceptance whether the request is illegal or out of range.
    always_comb begin
        lastByte = {1'b0, bus.req_addr} + {30'b0, size_bytes(bus.req_funct3[1:0])} - 33'd1;
        reqErr   = funct3_illegal(bus.req_we, bus.req_funct3) || (lastByte >= BYTE_LIMIT);
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = reqErr ? RESP : ACC0;
            ACC0: state_d = split ? ACC1 : RESP;
            ACC1: state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory port and response outputs; everything is zero outside the access states.
    always_comb begin
        bus.mem_wen       = 1'b0;
        bus.mem_address   = 32'b0;
        bus.mem_wdata     = 32'b0;
        bus.mem_byte_mask = 4'b0;
        case (state_q)
            ACC0: begin
                bus.mem_wen       = we_q;
                bus.mem_address   = wordAddr;
                bus.mem_wdata     = wdata0;
                bus.mem_byte_mask = mask0;
            end
            ACC1: begin
                bus.mem_wen       = we_q;
                bus.mem_address   = wordAddr + 32'd4;
                bus.mem_wdata     = wdata1;
                bus.mem_byte_mask = mask1;
            end
            default: ;
        endcase
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_err   = (state_q == RESP) && err_q;
        bus.rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? alignedRdata : 32'b0;
    end

    // State register, request capture and read-word capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            err_q    <= 1'b0;
            rd0_q    <= 32'b0;
            rd1_q    <= 32'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        err_q    <= reqErr;
                        rd0_q    <= 32'b0;
                        rd1_q    <= 32'b0;
                    end
                end
                ACC0:    rd0_q <= bus.mem_rdata;
                ACC1:    rd1_q <= bus.mem_rdata;
                default: ;
            endcase
        end
    end

endmodule
